// File: rtl/pcx_host_spi_master_if.sv
// pcx_host_spi_master_if: request/response bus of the PhotonCore-X host SPI initiator
interface pcx_host_spi_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    modport master (
        output req_valid, req_cmd, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );
    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/pcx_host_spi_master.sv
// pcx_host_spi_master: mode-0 SPI initiator serialising cmd/addr/data frames for the PhotonCore-X link
// Optional PCX_SPI_LOOPBACK_EN adds a loopback input that samples the registered MOSI instead of spi_miso.
module pcx_host_spi_master #(
    parameter int CLK_DIV  = 10,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pcx_host_spi_master_if.slave     bus,
`ifdef PCX_SPI_LOOPBACK_EN
    input  logic                     loopback,
`endif
    output logic                     spi_clk,
    output logic                     spi_mosi,
    input  logic                     spi_miso,
    output logic                     spi_cs_n
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t      state, state_next;
    logic [15:0] cnt;
    logic [8:0]  div;
    logic [5:0]  bcnt, last;
    logic        is_rd, bit_end, accept, long_cmd, miso_s;
    logic [63:0] sreg;
    logic [31:0] cap;
    assign bit_end  = div == 9'(2 * CLK_DIV - 1);
    assign accept   = bus.req_valid && bus.req_ready;
    assign long_cmd = bus.req_cmd inside {8'h01, 8'h02, 8'h03};
`ifdef PCX_SPI_LOOPBACK_EN
    assign miso_s = loopback ? spi_mosi : spi_miso;
`else
    assign miso_s = spi_miso;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? SETUP : IDLE;
            SETUP:   state_next = cnt == 16'(CS_SETUP - 1) ? SHIFT : SETUP;
            SHIFT:   state_next = bit_end && bcnt == last ? HOLD : SHIFT;
            HOLD:    state_next = cnt == 16'(CS_HOLD - 1) ? GAP : HOLD;
            GAP:     state_next = cnt == 16'(CS_GAP - 1) ? IDLE : GAP;
            default: state_next = IDLE;
        endcase
    end
    // Pins are registered from the current state, so every pin lags the state by exactly one clock.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt           <= '0;
            div           <= '0;
            bcnt          <= '0;
            last          <= '0;
            is_rd         <= 1'b0;
            sreg          <= '0;
            cap           <= '0;
            spi_cs_n      <= 1'b1;
            spi_clk       <= 1'b0;
            spi_mosi      <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            cnt <= state_next != state ? '0 : cnt + 16'd1;
            div <= state == SHIFT && !bit_end ? div + 9'd1 : '0;
            if (accept) begin
                sreg  <= long_cmd ? {bus.req_cmd, bus.req_addr, bus.req_cmd == 8'h02 ? 32'h0 : bus.req_wdata}
                                  : {bus.req_cmd, 56'h0};
                last  <= long_cmd ? 6'd63 : 6'd7;
                is_rd <= bus.req_cmd == 8'h02;
                bcnt  <= '0;
            end else if (state == SHIFT && bit_end) begin
                sreg <= {sreg[62:0], 1'b0};
                if (bcnt != last) bcnt <= bcnt + 6'd1;
            end
            if (state == SHIFT && div == 9'(CLK_DIV)) cap <= {cap[30:0], miso_s};
            spi_cs_n      <= !(state inside {SETUP, SHIFT, HOLD});
            spi_clk       <= state == SHIFT && div >= 9'(CLK_DIV);
            spi_mosi      <= (state == SETUP || state == SHIFT) && sreg[63];
            // Ready waits one extra IDLE cycle so cs_n stays high at least CS_GAP+1 clocks.
            bus.req_ready <= state == IDLE && state_next == IDLE;
            bus.busy      <= state_next != IDLE;
            bus.rsp_valid <= state == GAP && cnt == '0;
            if (state == GAP && cnt == '0) bus.rsp_rdata <= is_rd ? cap : '0;
        end
endmodule

// File: tb/tb_pcx_host_spi_master.sv
// tb_pcx_host_spi_master: scoreboard bench for the host SPI initiator (CLK_DIV=2, CS_SETUP=CS_HOLD=2, CS_GAP=3)
module tb_pcx_host_spi_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_clk, spi_mosi, spi_cs_n;
    logic spi_miso = 1'b0;
`ifdef PCX_SPI_LOOPBACK_EN
    logic loopback = 1'b0;
`endif
    pcx_host_spi_master_if bus();
    pcx_host_spi_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
`ifdef PCX_SPI_LOOPBACK_EN
        .loopback(loopback),
`endif
        .spi_clk(spi_clk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] mosi;
        int          bits;
        int          cyc;
    } frame_t;
    frame_t      frame_q[$];
    logic [31:0] rd_q[$];
    logic [63:0] miso_q[$];
    frame_t      f;
    int          n_cmp = 0, n_bad = 0;
    int          nrise = 0, nr_start = 0, cs_cyc = 0, gap_cyc = 100, base = 0;
    bit          in_frame = 1'b0, rdy_seen = 1'b0, skip = 1'b0, sl_act = 1'b0;
    logic [63:0] rx = '0, pat = '0, mask = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Mode-0 slave: first bit presented at cs_n fall, next bit after every SCLK fall.
    always @(spi_cs_n or negedge spi_clk) begin
        if (spi_cs_n !== 1'b0) sl_act = 1'b0;
        else if (!sl_act) begin
            sl_act = 1'b1;
            pat = miso_q.size() != 0 ? miso_q.pop_front() : 64'h0;
            spi_miso = pat[63];
        end else begin
            pat = {pat[62:0], 1'b0};
            spi_miso = pat[63];
        end
    end

    always @(posedge spi_clk) begin
        rx = {rx[62:0], spi_mosi};
        nrise++;
    end

    // Monitor: frame checks when cs_n returns high, response checks on rsp_valid.
    always @(negedge clk) begin
        if (spi_cs_n === 1'b0) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                cs_cyc = 0;
                rdy_seen = 1'b0;
                nr_start = nrise;
                chk("cs_high_gap_ge4", 64'(gap_cyc >= 4), 64'd1);
            end
            cs_cyc++;
            rdy_seen = rdy_seen | bus.req_ready;
        end else begin
            if (in_frame) begin
                in_frame = 1'b0;
                gap_cyc = 0;
                if (frame_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame: unexpected frame got 1 want 0");
                end else begin
                    f = frame_q.pop_front();
                    if (!skip) begin
                        mask = f.bits >= 64 ? '1 : (64'd1 << f.bits) - 64'd1;
                        chk("mosi_frame", rx & mask, f.mosi);
                        chk("sclk_rises", 64'(nrise - nr_start), 64'(f.bits));
                        chk("cs_low_cycles", 64'(cs_cyc), 64'(f.cyc));
                        chk("ready_low_in_frame", 64'(rdy_seen), 64'd0);
                    end
                end
            end
            gap_cyc++;
        end
        if (bus.rsp_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_valid: unexpected pulse got 1 want 0");
            end else chk("rsp_rdata", {32'h0, bus.rsp_rdata}, {32'h0, rd_q.pop_front()});
        end
    end

    task automatic send(input logic [7:0] cmd, input logic [23:0] addr, input logic [31:0] wd,
                        input logic [63:0] miso, input logic [63:0] mosi_exp, input int bits,
                        input int cyc, input logic [31:0] rd, input bit push_rd, input bit hold);
        frame_t e;
        int     i;
        e.mosi = mosi_exp;
        e.bits = bits;
        e.cyc  = cyc;
        frame_q.push_back(e);
        miso_q.push_back(miso);
        if (push_rd) rd_q.push_back(rd);
        @(negedge clk);
        bus.req_cmd   = cmd;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        for (i = 0; i < 3000 && bus.req_ready !== 1'b1; i++) @(negedge clk);
        if (i == 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: req_ready got 0 want 1");
        end
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000 && (bus.busy !== 1'b0 || frame_q.size() != 0 || rd_q.size() != 0); i++)
            @(negedge clk);
        if (i == 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy got %b want 0", bus.busy);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: sim time got %0t want < 1ms", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (5) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_cs_n", 64'(spi_cs_n), 64'd1);
        chk("rst_spi_clk", 64'(spi_clk), 64'd0);
        chk("rst_spi_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(bus.req_ready), 64'd1);
        base = nrise;
        repeat (50) @(negedge clk);
        chk("idle_no_sclk", 64'(nrise - base), 64'd0);
        chk("idle_cs_n", 64'(spi_cs_n), 64'd1);

        send(8'h01, 24'h000123, 32'hDEADBEEF, 64'h0, 64'h01000123_DEADBEEF, 64, 260, 32'h0, 1'b1, 1'b0);
        wait_idle();

        send(8'h04, 24'h0, 32'h0, 64'h0, 64'h04, 8, 36, 32'h0, 1'b1, 1'b1);
        send(8'h05, 24'h0, 32'h0, 64'h0, 64'h05, 8, 36, 32'h0, 1'b1, 1'b0);
        wait_idle();

        send(8'h02, 24'h000005, 32'hFFFFFFFF, 64'h00000000_00001ABC, 64'h02000005_00000000,
             64, 260, 32'h00001ABC, 1'b1, 1'b0);
        wait_idle();

        send(8'h01, 24'hABCDEF, 32'h12345678, 64'h0, 64'h01ABCDEF_12345678, 64, 260, 32'h0, 1'b0, 1'b0);
        base = nrise;
        for (int i = 0; i < 2000 && nrise - base < 20; i++) @(negedge clk);
        chk("bit20_reached", 64'(nrise - base), 64'd20);
        #1;
        skip = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cs_n", 64'(spi_cs_n), 64'd1);
        chk("async_rst_spi_clk", 64'(spi_clk), 64'd0);
        chk("async_rst_mosi", 64'(spi_mosi), 64'd0);
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        skip = 1'b0;
        send(8'h01, 24'h00BEEF, 32'hCAFEF00D, 64'h0, 64'h0100BEEF_CAFEF00D, 64, 260, 32'h0, 1'b1, 1'b0);
        wait_idle();

`ifdef PCX_SPI_LOOPBACK_EN
        loopback = 1'b1;
        send(8'h02, 24'h000077, 32'h0, 64'hFFFFFFFF_FFFFFFFF, 64'h02000077_00000000, 64, 260, 32'h0, 1'b1, 1'b0);
        wait_idle();
        loopback = 1'b0;
`endif

        repeat (10) @(negedge clk);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
        chk("frame_q_drained", 64'(frame_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pcx_host_spi_master.md
# pcx_host_spi_master

- Host-side SPI initiator for the PhotonCore-X control link.
- Accepts one register transaction per request, serialises it as a cmd/addr/data frame, and returns read data captured from MISO.
- Sits on the host/bring-up board and drives the FPGA core's SPI slave pins; the bench reuses it as the stimulus master for the core.

## Interface
Parameters:
- CLK_DIV, default 10: system clocks per SCLK half-period; legal range 2..255.
- CS_SETUP, default 4: clocks from cs_n fall to the first SCLK half-period; legal range ≥1.
- CS_HOLD, default 4: clocks from the last SCLK fall to cs_n rise; legal range ≥1.
- CS_GAP, default 8: minimum cs_n-high clocks between frames; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  transaction request.
- req_ready  out  1  high only in IDLE; accept on req_valid & req_ready.
- req_cmd  in  8  command byte (01 write phase, 02 read ADC, 03 write cal, 04 start forward, 05 start calibration).
- req_addr  in  24  register address, MSB first.
- req_wdata  in  32  write data, MSB first.
- rsp_valid  out  1  one-cycle pulse at frame end.
- rsp_rdata  out  32  read data; valid with rsp_valid.
- busy  out  1  high from acceptance until GAP completes.
- spi_clk  out  1  SCLK, mode 0 (idle low).
- spi_mosi  out  1  serial data to slave.
- spi_miso  in  1  serial data from slave.
- spi_cs_n  out  1  chip select, active low.

## Operation
- Reset values: req_ready=0 during reset and 1 on the first cycle after release. busy=0, rsp_valid=0, rsp_rdata=0, spi_clk=0, spi_mosi=0, spi_cs_n=1.
- Frame length is set by req_cmd at acceptance and latched with addr/wdata:
  - 01, 03: 8 bytes = cmd, addr[23:16], addr[15:8], addr[7:0], wdata[31:24..7:0].
  - 02: 8 bytes = cmd, 3 addr bytes, then 4 bytes with MOSI=0 while MISO is captured.
  - Any other value (including 04/05): 1 byte (cmd only).
- States and transitions:
  - IDLE → SETUP on accept; cs_n falls on the following edge.
  - SETUP: CS_SETUP cycles, SCLK low, MOSI = first bit.
  - SHIFT: each bit is CLK_DIV cycles SCLK low then CLK_DIV cycles SCLK high. MOSI changes only on the cycle SCLK falls (or on entry). MISO is sampled on the SCLK rising edge.
  - HOLD: CS_HOLD cycles after the last SCLK fall, SCLK low, MOSI=0.
  - GAP: cs_n=1. rsp_valid pulses on the first GAP cycle. Stay CS_GAP cycles, then IDLE.
- rsp_rdata:
  - cmd 02: last 32 sampled bits, first sampled bit in bit 31.
  - All other commands: 0.
  - Holds its value until the next rsp_valid.
- Bit counter is 6 bits and terminates at 8 or 64 bits. No wrap; the next frame reloads it.
- req_valid while busy is ignored. The requester holds the request; it is accepted on the first IDLE cycle.
- Back-to-back requests: cs_n high time is ≥ CS_GAP+1 cycles.
- rst_n low mid-frame: immediately cs_n=1, SCLK=0, MOSI=0, state IDLE. No rsp_valid; the partial frame is discarded.

## Timing
- Accept at edge T0: cs_n=0 from T1, first SCLK rise at T1+CS_SETUP+CLK_DIV.
- Bit period: 2·CLK_DIV clocks.
- Frame of B bits: cs_n low for CS_SETUP + 2·CLK_DIV·B + CS_HOLD clocks.
- rsp_valid: the cycle cs_n returns high.
- Next accept: no earlier than CS_GAP+1 cycles after rsp_valid.
- All outputs registered; no combinational path from spi_miso or req_* to any output.

## Configuration
- PCX_SPI_LOOPBACK_EN defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, MISO sampling uses the internally registered MOSI instead of spi_miso; pins toggle as normal.
  - When loopback=0, behaviour is as without the macro.
- PCX_SPI_LOOPBACK_EN undefined: no loopback port; MISO always from spi_miso.

## Test plan
- Parameters for all scenarios: CLK_DIV=2, CS_SETUP=CS_HOLD=2, CS_GAP=3.
- Reset and idle: hold rst_n=0 for 5 cycles, release → cs_n=1, spi_clk=0, req_ready=1 next cycle, no SCLK edges for 50 cycles.
- Write phase: cmd 01, addr 0x000123, wdata 0xDEADBEEF → MOSI bytes 01 00 01 23 DE AD BE EF; 64 SCLK rises; cs_n low for 260 cycles; rsp_valid once with rsp_rdata=0.
- Read ADC: cmd 02, addr 0x000005, slave model drives 0x00001ABC in bytes 5–8 → rsp_rdata=0x00001ABC; MOSI=0 for the last 32 bits.
- Short command and back-to-back: cmd 04 with req_valid held, followed by cmd 05 → two 8-SCLK frames; cs_n high ≥4 cycles between them; req_ready=0 throughout the first frame.
- Mid-frame reset: assert rst_n=0 at bit 20 of a cmd 01 frame → cs_n=1 and spi_clk=0 without waiting for a clock edge, no rsp_valid. A fresh cmd 01 after release completes correctly.
- Loopback (PCX_SPI_LOOPBACK_EN, loopback=1): cmd 02 → rsp_rdata=0x00000000 (MOSI low for data bytes). Check the captured address phase internally matches 0x02/addr.
